// File: rtl/led_bar_pkg.sv
// Shared definitions for the LED bar controller: FSM state type, level limits,
// and the level helpers (thermometer encode, saturating step).
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package led_bar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_BOTH   = 2'd3
  } state_e;

  localparam logic [3:0] LEVEL_INIT = 4'd3;
  localparam logic [3:0] LEVEL_MAX  = 4'd8;

  // Bar of lvl lit segments starting at bit 0: bit i is set iff i < lvl.
  function automatic logic [7:0] therm_encode(input logic [3:0] lvl);
    logic [7:0] bar;
    bar = '0;
    for (int i = 0; i < 8; i++) begin
      bar[i] = (lvl > 4'(i));
    end
    return bar;
  endfunction

  // One step up or down, pinned at 0 and LEVEL_MAX.
  function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic up);
    logic [3:0] nxt;
    nxt = lvl;
    if (up) begin
      if (lvl < LEVEL_MAX) nxt = lvl + 4'd1;
    end else begin
      if (lvl != 4'd0) nxt = lvl - 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, counting debouncer, press pulse.
// Latency: debounced level and press pulse change DEBOUNCE_CYCLES+2 edges after the pin settles.
// Backpressure: none; press_o is a single-cycle strobe and is never held off.
// Ports:
//   clk, rst_n  - system clock, async active-low reset (state forced to "released")
//   pb_i        - raw active-low button pin, asynchronous to clk
//   pressed_o   - debounced button level, 1 = pressed
//   press_o     - 1-cycle pulse in the cycle after the debounced level goes to pressed
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_i,
  output logic pressed_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pin polarity is kept through the synchronizer and debouncer (1 = released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pb_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive cycles where the synchronized pin disagrees with the
  // debounced value; any agreeing cycle drops the count back to zero. The
  // count tops out at DEBOUNCE_CYCLES-1, so it cannot wrap.
  always_comb begin
    deb_d   = deb_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign pressed_o = ~deb_q;
  assign press_o   = press_q;

endmodule

// File: rtl/led_bar_ctrl.sv
// Two-button LED bar: step down (pb1) / up (pb2) with hold auto-repeat and a
// both-buttons reset to LEVEL_INIT. Latency: DEBOUNCE_CYCLES+3 edges pin-to-leds.
// Backpressure: none; every accepted step is applied on the following edge.
// Ports:
//   clk, rst_n - system clock, async active-low reset (level=3, leds=8'h07, IDLE)
//   pb1, pb2   - raw active-low buttons: pb1 = step down, pb2 = step up
//   leds       - registered thermometer bar, bit i lit iff i < level
//   level      - registered fill level, 0..8
module led_bar_ctrl
  import led_bar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb1,
  input  logic       pb2,
  output logic [7:0] leds,
  output logic [3:0] level
);

  // One hold counter serves both DELAY and REPEAT; it is cleared on every
  // state change, so it only needs to reach the larger of the two limits.
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HCW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HCW-1:0] DELAY_LAST = HCW'(REPEAT_DELAY - 1);
  localparam logic [HCW-1:0] RATE_LAST  = HCW'(REPEAT_RATE - 1);

  logic dn_held, dn_press;
  logic up_held, up_press;

  pb_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pb1_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_i      (pb1),
    .pressed_o (dn_held),
    .press_o   (dn_press)
  );

  pb_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pb2_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_i      (pb2),
    .pressed_o (up_held),
    .press_o   (up_press)
  );

  state_e         state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           dir_up_q, dir_up_d;
  logic [3:0]     level_q, level_d;
  logic [7:0]     leds_q;

  // Which button is being held in DELAY/REPEAT, and the press of the other one.
  logic held_btn;
  logic other_press;

  assign held_btn    = dir_up_q ? up_held  : dn_held;
  assign other_press = dir_up_q ? dn_press : up_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      dir_up_q   <= 1'b0;
      level_q    <= LEVEL_INIT;
      leds_q     <= therm_encode(LEVEL_INIT);
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      dir_up_q   <= dir_up_d;
      level_q    <= level_d;
      // Encoded from the next level so leds and level move on the same edge.
      leds_q     <= therm_encode(level_d);
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    dir_up_d   = dir_up_q;
    level_d    = level_q;

    unique case (state_q)
      ST_IDLE: begin
        if (up_press && dn_press) begin
          level_d = LEVEL_INIT;
          state_d = ST_BOTH;
        end else if (up_press) begin
          level_d  = step_level(level_q, 1'b1);
          dir_up_d = 1'b1;
          state_d  = ST_DELAY;
        end else if (dn_press) begin
          level_d  = step_level(level_q, 1'b0);
          dir_up_d = 1'b0;
          state_d  = ST_DELAY;
        end
      end

      ST_DELAY: begin
        if (other_press) begin
          level_d = LEVEL_INIT;
          state_d = ST_BOTH;
        end else if (!held_btn) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == DELAY_LAST) begin
          level_d = step_level(level_q, dir_up_q);
          state_d = ST_REPEAT;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_REPEAT: begin
        if (other_press) begin
          level_d = LEVEL_INIT;
          state_d = ST_BOTH;
        end else if (!held_btn) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == RATE_LAST) begin
          // Steps at a limit are absorbed by step_level; timing carries on.
          level_d = step_level(level_q, dir_up_q);
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_BOTH: begin
        if (!up_held && !dn_held) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign leds  = leds_q;
  assign level = level_q;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Self-checking bench for led_bar_ctrl with short debounce/repeat timing.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_led_bar_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RR  = 4;

  logic       clk;
  logic       rst_n;
  logic       pb1;
  logic       pb2;
  logic [7:0] leds;
  logic [3:0] level;

  int vectors;
  int fails;

  led_bar_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pb1   (pb1),
    .pb2   (pb2),
    .leds  (leds),
    .level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pb1;
    logic       pb2;
    int         ncyc;
    logic [7:0] leds;
    logic [3:0] level;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp_leds, input logic [3:0] exp_level);
    vectors++;
    if (leds !== exp_leds || level !== exp_level) begin
      fails++;
      $display("FAIL %s: leds=%h level=%0d, expected leds=%h level=%0d",
               name, leds, level, exp_leds, exp_level);
    end
  endtask

  task automatic add(input logic p1, input logic p2, input int n,
                     input logic [7:0] l, input logic [3:0] v);
    vec_t r;
    r.pb1   = p1;
    r.pb2   = p2;
    r.ncyc  = n;
    r.leds  = l;
    r.level = v;
    tbl.push_back(r);
  endtask

  function automatic logic [7:0] bar_of(input int lvl);
    logic [7:0] m;
    m = 8'hFF << lvl;
    return ~m;
  endfunction

  // Hard stop in case the run stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails + 1);
    $fatal(1);
  end

  initial begin
    int lvl;
    vectors = 0;
    fails   = 0;
    pb1     = 1'b1;
    pb2     = 1'b1;
    rst_n   = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #2 check("reset_async", 8'h07, 4'd3);
    tick();
    tick();
    check("reset_held", 8'h07, 4'd3);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", 8'h07, 4'd3);

    // Bounce: never stable long enough to be accepted
    repeat (6) begin
      pb2 = 1'b0;
      tick();
      tick();
      pb2 = 1'b1;
      tick();
    end
    repeat (8) tick();
    check("bounce_rejected", 8'h07, 4'd3);

    // Exact latency: leds change on edge DEB+3 = 7
    pb2 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check("latency_edge6", 8'h07, 4'd3);
      if (e == 7) check("latency_edge7", 8'h0F, 4'd4);
    end
    pb2 = 1'b1;
    repeat (12) tick();
    check("single_step_release", 8'h0F, 4'd4);

    // Hold pb2 40 edges: steps at 7, 23, 27, 31, ... saturating at 8
    lvl = 4;
    pb2 = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 7 || (e >= 23 && ((e - 23) % 4) == 0)) begin
        if (lvl < 8) lvl = lvl + 1;
      end
      check($sformatf("hold_rpt_e%0d", e), bar_of(lvl), 4'(lvl));
    end
    pb2 = 1'b1;
    repeat (12) tick();
    check("saturate_top", 8'hFF, 4'd8);

    // Table: single presses down to 0, underflow attempts, a few ups
    add(0, 1, 10, 8'h7F, 4'd7); add(1, 1, 10, 8'h7F, 4'd7);
    add(0, 1, 10, 8'h3F, 4'd6); add(1, 1, 10, 8'h3F, 4'd6);
    add(0, 1, 10, 8'h1F, 4'd5); add(1, 1, 10, 8'h1F, 4'd5);
    add(0, 1, 10, 8'h0F, 4'd4); add(1, 1, 10, 8'h0F, 4'd4);
    add(0, 1, 10, 8'h07, 4'd3); add(1, 1, 10, 8'h07, 4'd3);
    add(0, 1, 10, 8'h03, 4'd2); add(1, 1, 10, 8'h03, 4'd2);
    add(0, 1, 10, 8'h01, 4'd1); add(1, 1, 10, 8'h01, 4'd1);
    add(0, 1, 10, 8'h00, 4'd0); add(1, 1, 10, 8'h00, 4'd0);
    add(0, 1, 10, 8'h00, 4'd0); add(1, 1, 10, 8'h00, 4'd0);
    add(0, 1, 10, 8'h00, 4'd0); add(1, 1, 10, 8'h00, 4'd0);
    add(0, 1, 10, 8'h00, 4'd0); add(1, 1, 10, 8'h00, 4'd0);
    add(1, 0, 10, 8'h01, 4'd1); add(1, 1, 10, 8'h01, 4'd1);
    add(1, 0, 10, 8'h03, 4'd2); add(1, 1, 10, 8'h03, 4'd2);
    add(0, 1, 10, 8'h01, 4'd1); add(1, 1, 10, 8'h01, 4'd1);
    add(0, 1, 10, 8'h00, 4'd0); add(1, 1, 10, 8'h00, 4'd0);
    foreach (tbl[i]) begin
      pb1 = tbl[i].pb1;
      pb2 = tbl[i].pb2;
      repeat (tbl[i].ncyc) tick();
      check($sformatf("table_%0d", i), tbl[i].leds, tbl[i].level);
    end

    // pb2 held, pb1 pressed during DELAY -> BOTH at level 3
    pb2 = 1'b0;
    repeat (8) tick();
    check("both_first_step", 8'h01, 4'd1);
    pb1 = 1'b0;
    repeat (10) tick();
    check("both_enter_delay", 8'h07, 4'd3);
    repeat (30) tick();
    check("both_no_steps", 8'h07, 4'd3);
    pb1 = 1'b1;
    repeat (30) tick();
    check("both_one_released", 8'h07, 4'd3);
    pb2 = 1'b1;
    repeat (12) tick();
    check("both_all_released", 8'h07, 4'd3);
    pb2 = 1'b0;
    repeat (10) tick();
    check("idle_after_both", 8'h0F, 4'd4);
    pb2 = 1'b1;
    repeat (10) tick();

    // Both pressed in the same cycle from IDLE
    pb1 = 1'b0;
    pb2 = 1'b0;
    repeat (10) tick();
    check("both_same_cycle", 8'h07, 4'd3);
    pb1 = 1'b1;
    pb2 = 1'b1;
    repeat (12) tick();
    check("both_same_release", 8'h07, 4'd3);

    // pb1 into REPEAT (3->2->1->0), then pb2 press -> BOTH
    pb1 = 1'b0;
    repeat (30) tick();
    check("repeat_down_floor", 8'h00, 4'd0);
    pb2 = 1'b0;
    repeat (10) tick();
    check("both_from_repeat", 8'h07, 4'd3);
    pb1 = 1'b1;
    pb2 = 1'b1;
    repeat (12) tick();
    check("both_repeat_release", 8'h07, 4'd3);

    // Reset during REPEAT with pb2 still held
    pb2 = 1'b0;
    repeat (28) tick();
    check("pre_reset_repeat", 8'h3F, 4'd6);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_hold", 8'h07, 4'd3);
    tick();
    tick();
    check("reset_mid_hold_held", 8'h07, 4'd3);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check("rehold_edge6", 8'h07, 4'd3);
      if (e == 7) check("rehold_edge7", 8'h0F, 4'd4);
    end
    pb2 = 1'b1;
    repeat (12) tick();
    check("rehold_release", 8'h0F, 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/led_bar_ctrl.md
LED_BAR_CTRL -- requirements
Module: led_bar_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized samples required to accept a button change.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, meaning hold cycles after a single-button press before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 5000000, meaning cycles between auto-repeat steps.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic SHALL be on posedge clk.
REQ-005 The block SHALL have port rst_n, input, 1, a reset that is asynchronous and active-low.
REQ-006 The block SHALL have port pb1, input, 1, raw asynchronous pushbutton, active-low, meaning "step down".
REQ-007 The block SHALL have port pb2, input, 1, raw asynchronous pushbutton, active-low, meaning "step up".
REQ-008 The block SHALL have port leds, output, 8, thermometer bar: bit i = 1 iff i < level.
REQ-009 The block SHALL have port level, output, 4, current fill level, range 0..8.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL restart the count.
REQ-011 Press events SHALL be 1-cycle pulses on the debounced active (pressed) edge; release SHALL be the debounced inactive level.
REQ-012 FSM states SHALL be IDLE, DELAY, REPEAT, BOTH.
REQ-013 IDLE: a press of exactly one button SHALL step level once (pb2 +1, pb1 -1) and go to DELAY with the hold counter cleared.
REQ-014 Press events of both buttons in the same cycle, or a press of the second button while in DELAY/REPEAT, SHALL set level to 3 and go to BOTH.
REQ-015 DELAY: after REPEAT_DELAY cycles of continuous hold, the block SHALL step once and enter REPEAT; REPEAT SHALL step once every REPEAT_RATE cycles.
REQ-016 DELAY/REPEAT: release of the held button SHALL return to IDLE with no further step.
REQ-017 BOTH: no steps SHALL occur; return to IDLE only when both debounced buttons are released.
REQ-018 level SHALL saturate at 0 and 8; a step beyond a limit SHALL leave level and leds unchanged, and the FSM SHALL still follow its transitions.
REQ-019 leds and level SHALL be registered and change on the clock edge after the step decision, with no glitching between steps.
REQ-020 Latency from a raw pin becoming stable to the leds change SHALL be exactly DEBOUNCE_CYCLES+3 clk edges.
REQ-021 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap; they SHALL be held or cleared on every state exit.

Reset
REQ-022 rst_n low SHALL asynchronously force: level=3, leds=8'b0000_0111, FSM=IDLE, counters=0, synchronizer and debounced outputs to "released".
REQ-023 Reset mid-hold SHALL discard the hold; a button still held after reset deassertion SHALL be treated as a new press after debounce.

Structure
REQ-024 Package led_bar_pkg SHALL hold the FSM state typedef, LEVEL_INIT=3, LEVEL_MAX=8 and the thermometer-encode function.
REQ-025 Sub-module pb_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4)
REQ-026 Reset -> leds=8'h07, level=3; pb2 low stable 7 cycles -> leds=8'h0F on edge 7.
REQ-027 pb2 bounce (low 2 cycles, high 1 cycle, repeated) -> leds stays 8'h07.
REQ-028 pb2 held 40 cycles -> steps at press, +16, +20, +24 ... saturating at leds=8'hFF, level=8.
REQ-029 pb1 pressed 4 times from level 1 -> level 0, leds=8'h00, and no underflow.
REQ-030 pb2 held, pb1 pressed during DELAY -> level=3, no steps until both released, then IDLE.
REQ-031 rst_n asserted during REPEAT with pb2 held -> immediate leds=8'h07; after release of reset, one step after DEBOUNCE_CYCLES+3.
